// File: rtl/chain_relax_if.sv
// chain_relax_if: groups the host handshake, host table access and
// constraint-stage signals of chain_relax_sequencer.
// master: host / constraint-stage side. slave: the sequencer.
interface chain_relax_if #(
    parameter int ADDR_W = 4
);
    logic              start;
    logic              busy;
    logic              done;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_x;
    logic [31:0]       wr_y;
    logic [ADDR_W-1:0] rd_addr;
    logic [31:0]       rd_x;
    logic [31:0]       rd_y;
    logic [31:0]       c_up_x;
    logic [31:0]       c_up_y;
    logic [31:0]       c_x;
    logic [31:0]       c_y;
    logic [31:0]       c_down_x;
    logic [31:0]       c_down_y;
    logic              c_valid;
    logic [31:0]       c_x_new;
    logic [31:0]       c_y_new;

    modport master (
        output start, wr_en, wr_addr, wr_x, wr_y, rd_addr, c_x_new, c_y_new,
        input  busy, done, rd_x, rd_y, c_up_x, c_up_y, c_x, c_y,
               c_down_x, c_down_y, c_valid
    );

    modport slave (
        input  start, wr_en, wr_addr, wr_x, wr_y, rd_addr, c_x_new, c_y_new,
        output busy, done, rd_x, rd_y, c_up_x, c_up_y, c_x, c_y,
               c_down_x, c_down_y, c_valid
    );
endinterface

// File: rtl/chain_relax_sequencer.sv
// chain_relax_sequencer: Gauss-Seidel sweeps over a table of Q16.16 (x, y)
// chain points. Each interior point is presented with its neighbours to an
// external combinational constraint stage and the result is written back in
// place. Endpoints 0 and N_POINTS-1 are pinned.
// Optional feature macro: CHAIN_RELAX_BIDIR_EN -- odd sweeps run descending.
module chain_relax_sequencer #(
    parameter int N_POINTS   = 16,
    parameter int ITERATIONS = 4,
    parameter int ADDR_W     = $clog2(N_POINTS)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           srst,
    chain_relax_if.slave   bus
);
    localparam int ITER_W = $clog2(ITERATIONS + 1);
    localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(32'd1);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(N_POINTS - 2);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [ADDR_W-1:0]   idx_r;
    logic [ITER_W-1:0]   iter_r;
    logic [31:0]         mem_x_r [N_POINTS];
    logic [31:0]         mem_y_r [N_POINTS];
    logic [31:0]         c_up_x_r, c_up_y_r, c_x_r, c_y_r, c_down_x_r, c_down_y_r;
    logic [31:0]         rd_x_r, rd_y_r;
    logic                busy_r, done_r, c_valid_r;
    logic                busy_nxt_s, done_nxt_s, c_valid_nxt_s;
    logic                sweep_desc_s;
    logic                last_pt_s;
    logic                final_sweep_s;
    logic [ITER_W-1:0]   iter_inc_s;
    logic [ADDR_W-1:0]   next_first_s;
    logic [ADDR_W-1:0]   up_idx_s;
    logic [ADDR_W-1:0]   down_idx_s;
    logic                wr_ok_s;
    logic                rd_ok_s;

    // Sweep direction, end-of-sweep detection and neighbour indices.
    always_comb begin
`ifdef CHAIN_RELAX_BIDIR_EN
        sweep_desc_s = iter_r[0];
`else
        sweep_desc_s = 1'b0;
`endif
        iter_inc_s    = iter_r + ITER_W'(32'd1);
        final_sweep_s = (iter_inc_s == ITER_W'(ITERATIONS));
        if (sweep_desc_s) begin
            last_pt_s = (idx_r == FIRST_IDX);
        end else begin
            last_pt_s = (idx_r == LAST_IDX);
        end
`ifdef CHAIN_RELAX_BIDIR_EN
        if (iter_inc_s[0]) begin
            next_first_s = LAST_IDX;
        end else begin
            next_first_s = FIRST_IDX;
        end
`else
        next_first_s = FIRST_IDX;
`endif
        up_idx_s   = idx_r - ADDR_W'(32'd1);
        down_idx_s = idx_r + ADDR_W'(32'd1);
        wr_ok_s    = (32'(bus.wr_addr) < 32'(N_POINTS));
        rd_ok_s    = (32'(bus.rd_addr) < 32'(N_POINTS));
    end

    // FSM state register plus registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            c_valid_r <= 1'b0;
        end else if (srst) begin
            state_r   <= ST_IDLE;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            c_valid_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            busy_r    <= busy_nxt_s;
            done_r    <= done_nxt_s;
            c_valid_r <= c_valid_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD:  state_nxt_s = ST_WRITE;
            ST_WRITE: begin
                if (last_pt_s && final_sweep_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            ST_DONE:  state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM outputs, decoded from the next state so they are registered.
    always_comb begin
        busy_nxt_s    = 1'b0;
        done_nxt_s    = 1'b0;
        c_valid_nxt_s = 1'b0;
        case (state_nxt_s)
            ST_LOAD:  busy_nxt_s = 1'b1;
            ST_WRITE: begin
                busy_nxt_s    = 1'b1;
                c_valid_nxt_s = 1'b1;
            end
            ST_DONE:  done_nxt_s = 1'b1;
            default: begin
                busy_nxt_s    = 1'b0;
                done_nxt_s    = 1'b0;
                c_valid_nxt_s = 1'b0;
            end
        endcase
    end

    // Point table, sweep counters and constraint-stage operand registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r      <= FIRST_IDX;
            iter_r     <= '0;
            c_up_x_r   <= 32'd0;
            c_up_y_r   <= 32'd0;
            c_x_r      <= 32'd0;
            c_y_r      <= 32'd0;
            c_down_x_r <= 32'd0;
            c_down_y_r <= 32'd0;
            for (int k = 0; k < N_POINTS; k++) begin
                mem_x_r[k] <= 32'd0;
                mem_y_r[k] <= 32'd0;
            end
        end else if (srst) begin
            idx_r      <= FIRST_IDX;
            iter_r     <= '0;
            c_up_x_r   <= 32'd0;
            c_up_y_r   <= 32'd0;
            c_x_r      <= 32'd0;
            c_y_r      <= 32'd0;
            c_down_x_r <= 32'd0;
            c_down_y_r <= 32'd0;
            for (int k = 0; k < N_POINTS; k++) begin
                mem_x_r[k] <= 32'd0;
                mem_y_r[k] <= 32'd0;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // Host write lands on the same edge as acceptance, so the
                    // first LOAD already sees it.
                    if (bus.wr_en && wr_ok_s) begin
                        mem_x_r[bus.wr_addr] <= bus.wr_x;
                        mem_y_r[bus.wr_addr] <= bus.wr_y;
                    end
                    if (bus.start) begin
                        idx_r  <= FIRST_IDX;
                        iter_r <= '0;
                    end
                end
                ST_LOAD: begin
                    c_up_x_r   <= mem_x_r[up_idx_s];
                    c_up_y_r   <= mem_y_r[up_idx_s];
                    c_x_r      <= mem_x_r[idx_r];
                    c_y_r      <= mem_y_r[idx_r];
                    c_down_x_r <= mem_x_r[down_idx_s];
                    c_down_y_r <= mem_y_r[down_idx_s];
                end
                ST_WRITE: begin
                    mem_x_r[idx_r] <= bus.c_x_new;
                    mem_y_r[idx_r] <= bus.c_y_new;
                    if (last_pt_s) begin
                        iter_r <= iter_inc_s;
                        idx_r  <= next_first_s;
                    end else if (sweep_desc_s) begin
                        idx_r <= up_idx_s;
                    end else begin
                        idx_r <= down_idx_s;
                    end
                end
                ST_DONE: begin
                    if (bus.wr_en && wr_ok_s) begin
                        mem_x_r[bus.wr_addr] <= bus.wr_x;
                        mem_y_r[bus.wr_addr] <= bus.wr_y;
                    end
                end
                default: begin
                    idx_r <= idx_r;
                end
            endcase
        end
    end

    // Host read port: one-cycle latency, zero for out-of-range indices.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_x_r <= 32'd0;
            rd_y_r <= 32'd0;
        end else if (srst) begin
            rd_x_r <= 32'd0;
            rd_y_r <= 32'd0;
        end else if (rd_ok_s) begin
            rd_x_r <= mem_x_r[bus.rd_addr];
            rd_y_r <= mem_y_r[bus.rd_addr];
        end else begin
            rd_x_r <= 32'd0;
            rd_y_r <= 32'd0;
        end
    end

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.c_valid  = c_valid_r;
    assign bus.c_up_x   = c_up_x_r;
    assign bus.c_up_y   = c_up_y_r;
    assign bus.c_x      = c_x_r;
    assign bus.c_y      = c_y_r;
    assign bus.c_down_x = c_down_x_r;
    assign bus.c_down_y = c_down_y_r;
    assign bus.rd_x     = rd_x_r;
    assign bus.rd_y     = rd_y_r;
endmodule

// File: tb/tb_chain_relax_sequencer.sv
// Directed bench for chain_relax_sequencer. Instance A: N_POINTS=4,
// ITERATIONS=2 with a stage adding 1.0 to x. Instance B: N_POINTS=5,
// ITERATIONS=2 with a stage copying the upper neighbour's x; y carries the
// point index so the write order is visible on c_y.
module tb_chain_relax_sequencer;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic srst  = 1'b0;
    int   errors = 0;
    int   checks = 0;

    chain_relax_if #(.ADDR_W(2)) ia();
    chain_relax_if #(.ADDR_W(3)) ib();

    assign ia.c_x_new = ia.c_x + 32'h0001_0000;
    assign ia.c_y_new = ia.c_y;
    assign ib.c_x_new = ib.c_up_x;
    assign ib.c_y_new = ib.c_y;

    chain_relax_sequencer #(.N_POINTS(4), .ITERATIONS(2), .ADDR_W(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .srst(srst), .bus(ia));
    chain_relax_sequencer #(.N_POINTS(5), .ITERATIONS(2), .ADDR_W(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .srst(srst), .bus(ib));

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_a(input logic [1:0] a, input logic [31:0] x);
        ia.wr_en = 1'b1; ia.wr_addr = a; ia.wr_x = x; ia.wr_y = 32'd0;
        step();
        ia.wr_en = 1'b0;
    endtask

    task automatic read_a(input logic [1:0] a, output logic [31:0] x);
        ia.rd_addr = a;
        step();
        x = ia.rd_x;
    endtask

    task automatic write_b(input logic [2:0] a, input logic [31:0] x, input logic [31:0] y);
        ib.wr_en = 1'b1; ib.wr_addr = a; ib.wr_x = x; ib.wr_y = y;
        step();
        ib.wr_en = 1'b0;
    endtask

    task automatic read_b(input logic [2:0] a, output logic [31:0] x, output logic [31:0] y);
        ib.rd_addr = a;
        step();
        x = ib.rd_x;
        y = ib.rd_y;
    endtask

    task automatic preload_a();
        write_a(2'd0, 32'h0000_0000);
        write_a(2'd1, 32'h0001_0000);
        write_a(2'd2, 32'h0002_0000);
        write_a(2'd3, 32'h0003_0000);
    endtask

    // Pulses start on A and counts busy and done cycles over a fixed window.
    task automatic run_a(output int busy_n, output int done_n);
        busy_n = 0; done_n = 0;
        ia.start = 1'b1;
        step();
        ia.start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ia.busy) busy_n++;
            if (ia.done) done_n++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        @(negedge clk);
        checks++;
        if ({ia.busy, ia.done, ia.c_valid} !== 3'b000) begin
            errors++; $display("FAIL reset_status: got %b expected 000", {ia.busy, ia.done, ia.c_valid});
        end
        checks++;
        if ({ia.c_up_x, ia.c_x, ia.c_down_x, ia.c_y} !== 128'd0) begin
            errors++; $display("FAIL reset_c_regs: got %h expected 0", {ia.c_up_x, ia.c_x, ia.c_down_x, ia.c_y});
        end
        checks++;
        if ({ia.rd_x, ia.rd_y, ib.rd_x, ib.busy} !== 97'd0) begin
            errors++; $display("FAIL reset_rd: got %h expected 0", {ia.rd_x, ia.rd_y, ib.rd_x, ib.busy});
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        int b, d;
        logic [31:0] v;
        logic [31:0] exp_x [4];
        exp_x[0] = 32'h0000_0000; exp_x[1] = 32'h0003_0000;
        exp_x[2] = 32'h0004_0000; exp_x[3] = 32'h0003_0000;
        preload_a();
        run_a(b, d);
        checks++;
        if (b !== 8) begin errors++; $display("FAIL basic_busy_len: got %0d expected 8", b); end
        checks++;
        if (d !== 1) begin errors++; $display("FAIL basic_done_pulses: got %0d expected 1", d); end
        for (int k = 0; k < 4; k++) begin
            read_a(2'(k), v);
            checks++;
            if (v !== exp_x[k]) begin
                errors++; $display("FAIL basic_x%0d: got %h expected %h", k, v, exp_x[k]);
            end
        end
    endtask

    task automatic test_start_with_write();
        bit seen = 1'b0;
        int b, d;
        ia.wr_en = 1'b1; ia.wr_addr = 2'd1; ia.wr_x = 32'h0007_0000; ia.wr_y = 32'd0;
        ia.start = 1'b1;
        step();
        ia.wr_en = 1'b0; ia.start = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            if (ia.c_valid) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL start_wr_cvalid: got no c_valid expected c_valid within 10 cycles");
        end else if (ia.c_x !== 32'h0007_0000) begin
            errors++; $display("FAIL start_wr_first_cx: got %h expected 00070000", ia.c_x);
        end
        b = 0; d = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ia.done) d++;
        end
        checks++;
        if (d !== 1) begin errors++; $display("FAIL start_wr_done: got %0d expected 1", d); end
    endtask

    task automatic test_busy_block();
        int b = 0;
        int d = 0;
        int bad = 0;
        logic [31:0] v;
        preload_a();
        ia.rd_addr = 2'd2;
        ia.start = 1'b1;
        step();
        ia.start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ia.busy) b++;
            if (ia.done) d++;
            if (ia.rd_x === 32'hDEAD_BEEF) bad++;
            if (k == 3) begin
                ia.start = 1'b1; ia.wr_en = 1'b1; ia.wr_addr = 2'd2; ia.wr_x = 32'hDEAD_BEEF;
            end else begin
                ia.start = 1'b0; ia.wr_en = 1'b0;
            end
        end
        checks++;
        if (b !== 8) begin errors++; $display("FAIL block_busy_len: got %0d expected 8", b); end
        checks++;
        if (d !== 1) begin errors++; $display("FAIL block_done: got %0d expected 1", d); end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL block_deadbeef: got %0d hits expected 0", bad); end
        read_a(2'd2, v);
        checks++;
        if (v !== 32'h0004_0000) begin errors++; $display("FAIL block_x2: got %h expected 00040000", v); end
    endtask

    task automatic test_inplace_order();
        int b = 0;
        int n = 0;
        logic [31:0] tr [6];
        logic [31:0] exp_tr [6];
        logic [31:0] exp_x [5];
        logic [31:0] vx, vy;
        exp_x[0] = 32'd5; exp_x[1] = 32'd5; exp_x[2] = 32'd5; exp_x[3] = 32'd5; exp_x[4] = 32'd9;
        exp_tr[0] = 32'd1; exp_tr[1] = 32'd2; exp_tr[2] = 32'd3;
`ifdef CHAIN_RELAX_BIDIR_EN
        exp_tr[3] = 32'd3; exp_tr[4] = 32'd2; exp_tr[5] = 32'd1;
`else
        exp_tr[3] = 32'd1; exp_tr[4] = 32'd2; exp_tr[5] = 32'd3;
`endif
        write_b(3'd0, 32'd5, 32'd0);
        write_b(3'd1, 32'd0, 32'd1);
        write_b(3'd2, 32'd0, 32'd2);
        write_b(3'd3, 32'd0, 32'd3);
        write_b(3'd4, 32'd9, 32'd4);
        ib.start = 1'b1;
        step();
        ib.start = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (ib.busy) b++;
            if (ib.c_valid) begin
                if (n < 6) tr[n] = ib.c_y;
                n++;
            end
        end
        checks++;
        if (b !== 12) begin errors++; $display("FAIL order_busy_len: got %0d expected 12", b); end
        checks++;
        if (n !== 6) begin
            errors++; $display("FAIL order_writes: got %0d expected 6", n);
        end else begin
            for (int k = 0; k < 6; k++) begin
                checks++;
                if (tr[k] !== exp_tr[k]) begin
                    errors++; $display("FAIL order_trace%0d: got %0d expected %0d", k, tr[k], exp_tr[k]);
                end
            end
        end
        for (int k = 0; k < 5; k++) begin
            read_b(3'(k), vx, vy);
            checks++;
            if (vx !== exp_x[k] || vy !== 32'(k)) begin
                errors++; $display("FAIL order_pt%0d: got %h/%h expected %h/%h", k, vx, vy, exp_x[k], 32'(k));
            end
        end
        read_b(3'd5, vx, vy);
        checks++;
        if ({vx, vy} !== 64'd0) begin errors++; $display("FAIL rd_out_of_range: got %h expected 0", {vx, vy}); end
    endtask

    task automatic test_reset_midrun();
        int b = 0;
        int d;
        logic [31:0] v;
        preload_a();
        ia.start = 1'b1;
        step();
        ia.start = 1'b0;
        for (int k = 0; k < 20 && b < 6; k++) begin
            @(negedge clk);
            if (ia.busy) b++;
        end
        checks++;
        if (b !== 6) begin errors++; $display("FAIL midrun_reach: got %0d busy cycles expected 6", b); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ia.busy, ia.c_valid} !== 2'b00) begin
            errors++; $display("FAIL midrun_abort: got %b expected 00", {ia.busy, ia.c_valid});
        end
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            read_a(2'(k), v);
            checks++;
            if (v !== 32'd0) begin errors++; $display("FAIL midrun_clear%0d: got %h expected 0", k, v); end
        end
        preload_a();
        run_a(b, d);
        checks++;
        if (b !== 8 || d !== 1) begin
            errors++; $display("FAIL rerun: got busy=%0d done=%0d expected busy=8 done=1", b, d);
        end
        read_a(2'd1, v);
        checks++;
        if (v !== 32'h0003_0000) begin errors++; $display("FAIL rerun_x1: got %h expected 00030000", v); end
    endtask

    initial begin
        ia.start = 1'b0; ia.wr_en = 1'b0; ia.wr_addr = 2'd0; ia.wr_x = 32'd0; ia.wr_y = 32'd0; ia.rd_addr = 2'd0;
        ib.start = 1'b0; ib.wr_en = 1'b0; ib.wr_addr = 3'd0; ib.wr_x = 32'd0; ib.wr_y = 32'd0; ib.rd_addr = 3'd0;
        test_reset();
        test_basic();
        test_start_with_write();
        test_busy_block();
        test_inplace_order();
        test_reset_midrun();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
